// File: rtl/int_arbiter_if.sv
// ----------------------------------------------------------------------------
// int_arbiter_if
// Bus window (Bridge side) and CPU interrupt handshake for int_arbiter.
//   Addr    word address [31:2]; only [3:2] is decoded by the arbiter
//   WE      register write strobe, one cycle per write
//   Din     write data
//   Dout    read data, combinational from Addr[3:2]
//   HWInt   pending & mask, to the CPU HWInt input
//   int_req registered interrupt request
//   int_id  index of requested source, valid while int_req=1
//   int_ack CPU acknowledge, single-cycle pulse
// master = Bridge/CPU side, slave = arbiter side.
// ----------------------------------------------------------------------------
interface int_arbiter_if #(
    parameter int N_SRC = 6
);
    logic [31:2]      Addr;
    logic             WE;
    logic [31:0]      Din;
    logic [31:0]      Dout;
    logic [N_SRC-1:0] HWInt;
    logic             int_req;
    logic [2:0]       int_id;
    logic             int_ack;

    modport master (
        output Addr, WE, Din, int_ack,
        input  Dout, HWInt, int_req, int_id
    );

    modport slave (
        input  Addr, WE, Din, int_ack,
        output Dout, HWInt, int_req, int_id
    );
endinterface

// File: rtl/int_arbiter.sv
// ----------------------------------------------------------------------------
// int_arbiter
// Latches, masks and prioritises up to N_SRC interrupt sources and runs a
// request / acknowledge / end-of-interrupt handshake with the CPU.
// Register window (Addr[3:2]):
//   0 PENDING  read; edge-mode bits are write-1-to-clear
//   1 MASK     read/write, 1 = enabled
//   2 EDGE     read/write, 1 = rising-edge mode, 0 = level mode
//   3 STATUS   read {state[17:16], int_req[8], int_id[2:0]}; any write = EOI
// Ports:
//   clk    system clock
//   reset  asynchronous, active-low
//   src    raw IRQ lines, synchronous to clk
//   bus    int_arbiter_if.slave (register window + CPU handshake)
// ----------------------------------------------------------------------------

// Per-source capture: one-cycle input stage, then edge detect or level follow.
module int_arbiter_cell (
    input  logic clk,
    input  logic reset,
    input  logic src,
    input  logic edge_mode,
    input  logic w1c,
    input  logic ack_clr,
    output logic pending
);
    logic src_q, src_qq, pend_e;

    // The rising edge is detected on the registered copy, so an edge bit
    // sets one edge after src is first sampled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            src_q  <= 1'b0;
            src_qq <= 1'b0;
            pend_e <= 1'b0;
        end else begin
            src_q  <= src;
            src_qq <= src_q;
            if (!edge_mode)
                pend_e <= 1'b0;
            else if (src_q && !src_qq)
                pend_e <= 1'b1;          // a new edge beats a same-cycle clear
            else if (w1c || ack_clr)
                pend_e <= 1'b0;
        end
    end

    // Level sources simply follow the sampled line.
    assign pending = edge_mode ? pend_e : src_q;
endmodule

module int_arbiter #(
    parameter int N_SRC = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] src,
    int_arbiter_if.slave     bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             int_req_q, int_req_d;
    logic [2:0]       int_id_q, int_id_d;
    logic [N_SRC-1:0] mask_q, edge_q;
    logic [N_SRC-1:0] pending, hw, w1c, ack_clr;
    logic [2:0]       winner;
    logic [1:0]       sel;
    logic             eoi, ack_fire;
    logic             unused_bus;

    assign sel        = bus.Addr[3:2];
    assign eoi        = bus.WE && (sel == 2'd3);
    assign ack_fire   = (state_q == REQ) && bus.int_ack;
    assign w1c        = (bus.WE && (sel == 2'd0)) ? bus.Din[N_SRC-1:0] : '0;
    assign unused_bus = ^{bus.Addr[31:4], bus.Din};

    // Ack clears only the source being serviced; the cell ignores it in level mode.
    always_comb begin
        ack_clr = '0;
        for (int i = 0; i < N_SRC; i++)
            ack_clr[i] = ack_fire && (int_id_q == 3'(i));
    end

    for (genvar i = 0; i < N_SRC; i++) begin : g_src
        int_arbiter_cell u_cell (
            .clk       (clk),
            .reset     (reset),
            .src       (src[i]),
            .edge_mode (edge_q[i]),
            .w1c       (w1c[i]),
            .ack_clr   (ack_clr[i]),
            .pending   (pending[i])
        );
    end

    assign hw        = pending & mask_q;
    assign bus.HWInt = hw;

    // Lowest index wins: scan downwards so the last hit is the smallest.
    always_comb begin
        winner = 3'd0;
        for (int i = N_SRC - 1; i >= 0; i--)
            if (hw[i]) winner = 3'(i);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mask_q <= '0;
            edge_q <= '0;
        end else if (bus.WE) begin
            if (sel == 2'd1) mask_q <= bus.Din[N_SRC-1:0];
            if (sel == 2'd2) edge_q <= bus.Din[N_SRC-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            int_req_q <= 1'b0;
            int_id_q  <= 3'd0;
        end else begin
            state_q   <= state_d;
            int_req_q <= int_req_d;
            int_id_q  <= int_id_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        int_req_d = int_req_q;
        int_id_d  = int_id_q;
        unique case (state_q)
            IDLE: if (|hw) begin
                int_id_d  = winner;
                int_req_d = 1'b1;
                state_d   = REQ;
            end
            // int_id is frozen here; later arrivals wait for the next round.
            REQ: if (bus.int_ack) begin
                int_req_d = 1'b0;
                state_d   = SERVICE;
            end
            SERVICE: if (eoi) state_d = IDLE;
            default: begin
                state_d   = IDLE;
                int_req_d = 1'b0;
            end
        endcase
    end

    assign bus.int_req = int_req_q;
    assign bus.int_id  = int_id_q;

    always_comb begin
        bus.Dout = '0;
        unique case (sel)
            2'd0: bus.Dout[N_SRC-1:0] = pending;
            2'd1: bus.Dout[N_SRC-1:0] = mask_q;
            2'd2: bus.Dout[N_SRC-1:0] = edge_q;
            2'd3: begin
                bus.Dout[2:0]   = int_id_q;
                bus.Dout[8]     = int_req_q;
                bus.Dout[17:16] = state_q;
            end
            default: bus.Dout = '0;
        endcase
    end
endmodule

// File: tb/tb_int_arbiter.sv
// Directed bench for int_arbiter: register readback, edge/level capture,
// priority, handshake and asynchronous reset.
module tb_int_arbiter;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] src = '0;
    int         errors = 0;
    int         checks = 0;
    logic [31:0] rd;

    int_arbiter_if #(.N_SRC(6)) bus ();

    int_arbiter #(.N_SRC(6)) dut (
        .clk   (clk),
        .reset (reset),
        .src   (src),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // All stimulus moves 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_reg(input logic [1:0] a, output logic [31:0] d);
        bus.Addr = {28'd0, a};
        #1;
        d = bus.Dout;
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
        bus.Addr = {28'd0, a};
        bus.Din  = d;
        bus.WE   = 1'b1;
        tick();
        bus.WE   = 1'b0;
    endtask

    task automatic pulse_ack();
        bus.int_ack = 1'b1;
        tick();
        bus.int_ack = 1'b0;
    endtask

    task automatic test_reset();
        src = 6'h3F;
        reset = 1'b0;
        tick(); tick();
        checks++; if (bus.HWInt !== 6'h00) begin errors++; $display("FAIL rst_hwint: got %h want 00", bus.HWInt); end
        checks++; if (bus.int_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", bus.int_req); end
        for (int a = 0; a < 4; a++) begin
            rd_reg(2'(a), rd);
            checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rst_read%0d: got %h want 00000000", a, rd); end
        end
        src = '0;
        reset = 1'b1;
        tick();
        wr_reg(2'd1, 32'h3F);
        wr_reg(2'd2, 32'h07);
        rd_reg(2'd1, rd);
        checks++; if (rd !== 32'h3F) begin errors++; $display("FAIL rb_mask: got %h want 0000003f", rd); end
        rd_reg(2'd2, rd);
        checks++; if (rd !== 32'h07) begin errors++; $display("FAIL rb_edge: got %h want 00000007", rd); end
        wr_reg(2'd1, 32'h0);
        wr_reg(2'd2, 32'h0);
    endtask

    task automatic test_edge_path();
        wr_reg(2'd1, 32'h1);
        wr_reg(2'd2, 32'h1);
        src[0] = 1'b1;
        tick();
        src[0] = 1'b0;
        rd_reg(2'd0, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL edge_early: got %h want 00000000", rd); end
        tick();
        rd_reg(2'd0, rd);
        checks++; if (rd !== 32'h1) begin errors++; $display("FAIL edge_pend: got %h want 00000001", rd); end
        checks++; if (bus.HWInt !== 6'h01) begin errors++; $display("FAIL edge_hwint: got %h want 01", bus.HWInt); end
        checks++; if (bus.int_req !== 1'b0) begin errors++; $display("FAIL edge_req_early: got %b want 0", bus.int_req); end
        tick();
        checks++; if (bus.int_req !== 1'b1 || bus.int_id !== 3'd0) begin errors++; $display("FAIL edge_req: got req=%b id=%0d want req=1 id=0", bus.int_req, bus.int_id); end
        rd_reg(2'd3, rd);
        checks++; if (rd !== 32'h0001_0100) begin errors++; $display("FAIL edge_status_req: got %h want 00010100", rd); end
        // EOI in REQ must be ignored
        wr_reg(2'd3, 32'h0);
        rd_reg(2'd3, rd);
        checks++; if (rd !== 32'h0001_0100) begin errors++; $display("FAIL eoi_in_req: got %h want 00010100", rd); end
        pulse_ack();
        checks++; if (bus.int_req !== 1'b0) begin errors++; $display("FAIL ack_req: got %b want 0", bus.int_req); end
        rd_reg(2'd0, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL ack_pend: got %h want 00000000", rd); end
        rd_reg(2'd3, rd);
        checks++; if (rd !== 32'h0002_0000) begin errors++; $display("FAIL ack_status: got %h want 00020000", rd); end
        wr_reg(2'd3, 32'h0);
        rd_reg(2'd3, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL eoi_status: got %h want 00000000", rd); end
    endtask

    task automatic test_priority();
        wr_reg(2'd2, 32'h3F);
        wr_reg(2'd1, 32'h3F);
        src = 6'h12;
        tick(); tick(); tick();
        checks++; if (bus.int_req !== 1'b1 || bus.int_id !== 3'd1) begin errors++; $display("FAIL prio_first: got req=%b id=%0d want req=1 id=1", bus.int_req, bus.int_id); end
        src = 6'h13;
        tick(); tick(); tick();
        checks++; if (bus.int_id !== 3'd1) begin errors++; $display("FAIL prio_frozen: got id=%0d want 1", bus.int_id); end
        rd_reg(2'd0, rd);
        checks++; if (rd !== 32'h13) begin errors++; $display("FAIL prio_pend: got %h want 00000013", rd); end
        pulse_ack();
        rd_reg(2'd0, rd);
        checks++; if (rd !== 32'h11) begin errors++; $display("FAIL prio_ackclr: got %h want 00000011", rd); end
        wr_reg(2'd3, 32'h0);
        checks++; if (bus.int_req !== 1'b0) begin errors++; $display("FAIL prio_idle_gap: got %b want 0", bus.int_req); end
        tick();
        checks++; if (bus.int_req !== 1'b1 || bus.int_id !== 3'd0) begin errors++; $display("FAIL prio_second: got req=%b id=%0d want req=1 id=0", bus.int_req, bus.int_id); end
        pulse_ack();
        wr_reg(2'd3, 32'h0);
        tick();
        checks++; if (bus.int_id !== 3'd4) begin errors++; $display("FAIL prio_third: got id=%0d want 4", bus.int_id); end
        pulse_ack();
        wr_reg(2'd3, 32'h0);
        src = '0;
        wr_reg(2'd1, 32'h0);
        wr_reg(2'd2, 32'h0);
        tick(); tick();
    endtask

    task automatic test_level();
        wr_reg(2'd1, 32'h04);
        src[2] = 1'b1;
        tick(); tick();
        checks++; if (bus.int_req !== 1'b1 || bus.int_id !== 3'd2) begin errors++; $display("FAIL lvl_req: got req=%b id=%0d want req=1 id=2", bus.int_req, bus.int_id); end
        pulse_ack();
        wr_reg(2'd3, 32'h0);
        tick();
        checks++; if (bus.int_req !== 1'b1 || bus.int_id !== 3'd2) begin errors++; $display("FAIL lvl_reassert: got req=%b id=%0d want req=1 id=2", bus.int_req, bus.int_id); end
        wr_reg(2'd0, 32'h04);
        rd_reg(2'd0, rd);
        checks++; if (rd !== 32'h04) begin errors++; $display("FAIL lvl_w1c: got %h want 00000004", rd); end
        src[2] = 1'b0;
        tick();
        rd_reg(2'd0, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL lvl_drop: got %h want 00000000", rd); end
        pulse_ack();
        wr_reg(2'd3, 32'h0);
        wr_reg(2'd1, 32'h0);
    endtask

    task automatic test_w1c_collision();
        wr_reg(2'd2, 32'h08);
        src[3] = 1'b1;
        tick();
        // this write lands on the edge where the bit sets
        wr_reg(2'd0, 32'h08);
        rd_reg(2'd0, rd);
        checks++; if (rd !== 32'h08) begin errors++; $display("FAIL w1c_collide: got %h want 00000008", rd); end
        wr_reg(2'd0, 32'h08);
        rd_reg(2'd0, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL w1c_clear: got %h want 00000000", rd); end
        src[3] = 1'b0;
        wr_reg(2'd2, 32'h0);
    endtask

    task automatic test_midop_reset();
        wr_reg(2'd1, 32'h1);
        wr_reg(2'd2, 32'h1);
        src[0] = 1'b1;
        tick();
        src[0] = 1'b0;
        tick(); tick();
        pulse_ack();
        rd_reg(2'd3, rd);
        checks++; if (rd !== 32'h0002_0000) begin errors++; $display("FAIL mid_service: got %h want 00020000", rd); end
        #1 reset = 1'b0;
        #1;
        rd_reg(2'd3, rd);
        checks++; if (rd !== 32'h0 || bus.int_req !== 1'b0) begin errors++; $display("FAIL mid_reset: got status=%h req=%b want 0", rd, bus.int_req); end
        rd_reg(2'd1, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL mid_mask: got %h want 00000000", rd); end
        reset = 1'b1;
        tick();
        wr_reg(2'd3, 32'h0);
        pulse_ack();
        tick();
        rd_reg(2'd3, rd);
        checks++; if (rd !== 32'h0 || bus.int_req !== 1'b0) begin errors++; $display("FAIL mid_stray: got status=%h req=%b want 0", rd, bus.int_req); end
    endtask

    initial begin
        bus.Addr    = '0;
        bus.WE      = 1'b0;
        bus.Din     = '0;
        bus.int_ack = 1'b0;
        #1;
        test_reset();
        test_edge_path();
        test_priority();
        test_level();
        test_w1c_collision();
        test_midop_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
